mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 Parameter DATA_W, default 16, SHALL set the memory word width.
REQ-003 Parameter ADDR_W, default 10, SHALL set the memory address width.
REQ-004 Parameter MEM_LAT, default 1, legal range 1..4, SHALL set the number of cycles the memory access phase lasts.
REQ-005 Port clk, input, width 1, SHALL be the rising-edge clock.
REQ-006 Port rst_n, input, width 1, SHALL be the asynchronous active-low reset.
REQ-007 Port f_req, input, width 1, SHALL be the fetch-unit read request.
REQ-008 Port f_addr, input, width ADDR_W, SHALL be the fetch address.
REQ-009 Ports f_gnt and f_done, outputs, width 1 each, SHALL pulse for the fetch grant and the fetch completion respectively.
REQ-010 Port f_rdata, output, width DATA_W, SHALL carry the fetched word.
REQ-011 Ports d_req and d_we, inputs, width 1 each, SHALL be the load/store request and its write enable.
REQ-012 Ports d_addr (width ADDR_W) and d_wdata (width DATA_W), inputs, SHALL carry the data address and the store data.
REQ-013 Ports d_gnt and d_done, outputs, width 1 each, SHALL pulse for the data grant and the data completion respectively.
REQ-014 Port d_rdata, output, width DATA_W, SHALL carry the loaded word.
REQ-015 Ports mem_en and mem_we, outputs, width 1 each, SHALL be the single-port RAM enable and write strobe.
REQ-016 Ports mem_addr (width ADDR_W) and mem_wdata (width DATA_W), outputs, SHALL drive the RAM address and write data.
REQ-017 Port mem_rdata, input, width DATA_W, SHALL be the RAM read data.
REQ-018 Port busy, output, width 1, SHALL be high whenever the state is not IDLE.

Function
REQ-019 The FSM SHALL have three states: IDLE, ACCESS and RESP.
REQ-020 In IDLE with any request high, the block SHALL pick a winner and latch its address, write data and write enable; f_req is latched with write enable 0.
REQ-021 On that same edge the FSM SHALL enter ACCESS, and the winner's gnt SHALL be registered high for exactly one cycle.
REQ-022 In ACCESS, mem_en SHALL be 1, mem_addr, mem_wdata and mem_we SHALL be the latched values, and a cycle counter SHALL run from 0 to MEM_LAT-1.
REQ-023 When the counter reaches MEM_LAT-1, the FSM SHALL go to RESP.
REQ-024 In RESP, for a read, mem_rdata SHALL be registered into the winner's rdata, the winner's done SHALL be high for one cycle, and the FSM SHALL return to IDLE.
REQ-025 For a write, d_rdata SHALL hold its previous value while d_done still pulses.
REQ-026 Latency: a request sampled in IDLE at edge n SHALL produce gnt in cycle n+1 and done in cycle n+1+MEM_LAT.
REQ-027 The minimum spacing between two accesses SHALL be MEM_LAT+2 cycles.
REQ-028 A requester SHALL hold req and its operands until gnt; a req dropped before gnt SHALL count as withdrawn and no access occurs.
REQ-029 Requests arriving during ACCESS or RESP SHALL be ignored until IDLE.
REQ-030 Outside their pulses, gnt and done SHALL be 0, and mem_en and mem_we SHALL be 0 outside ACCESS.
REQ-031 f_rdata and d_rdata SHALL hold their values until overwritten by a later read.

Reset
REQ-032 Asserting rst_n low SHALL asynchronously force IDLE, set the counter to 0, set every gnt, done, mem_en, mem_we and busy to 0, and set mem_addr, mem_wdata, f_rdata and d_rdata to 0.
REQ-033 Under ARB_ROUND_ROBIN_EN, reset SHALL also set the last-winner register to DATA.
REQ-034 A reset during ACCESS SHALL abort the access with no done pulse; the requester SHALL re-request.

Configuration
REQ-035 With macro ARB_ROUND_ROBIN_EN defined, simultaneous requests SHALL be granted to the requester that was not the last winner, and the last-winner register SHALL update on every grant.
REQ-036 Without ARB_ROUND_ROBIN_EN, arbitration SHALL be fixed priority with data over fetch, and no last-winner register SHALL exist.

Structure
REQ-037 State encodings (IDLE, ACCESS, RESP), the requester IDs (FETCH, DATA) and the DATA_W and ADDR_W defaults SHALL live in the shared constants include.
REQ-038 Winner selection SHALL be a separate sub-module, arb_pick, with inputs f_req, d_req and last and output winner; its only state is the last-winner register in mem_arbiter.

Verification
REQ-039 With MEM_LAT=1, f_req=1 and f_addr=0x005 sampled at edge 0, and mem_rdata=0xBEEF: f_gnt SHALL be high in cycle 1, mem_en SHALL be high with mem_addr=0x005 in cycle 1, f_done SHALL be high in cycle 2 and f_rdata SHALL be 0xBEEF.
REQ-040 With d_req=1, d_we=1, d_addr=0x3FF and d_wdata=0x1234: there SHALL be one ACCESS cycle with mem_we=1, mem_addr=0x3FF and mem_wdata=0x1234, then d_done, and d_rdata SHALL be unchanged.
REQ-041 With f_req and d_req both held high for 12 cycles at MEM_LAT=1: with the macro, grants SHALL be issued in the order F, D, F, D; without the macro, only d_gnt SHALL ever pulse.
REQ-042 At MEM_LAT=3, rst_n driven low in the second ACCESS cycle SHALL drop mem_en immediately, produce no done, and leave busy=0.
REQ-043 f_req high for one cycle during ACCESS of a data write SHALL produce no f_gnt and no second access.
REQ-044 At MEM_LAT=4, the done pulse SHALL occur exactly 5 cycles after the request edge, and busy SHALL be high for 5 cycles.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the fetch/data memory arbiter: FSM encodings, requester IDs, width defaults.
// Optional round-robin arbitration is enabled with macro ARB_ROUND_ROBIN_EN.
package mem_arbiter_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 10;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  typedef enum logic {
    REQ_FETCH = 1'b0,
    REQ_DATA  = 1'b1
  } req_id_t;

  localparam int CNT_W = 2;

  // Last ACCESS-cycle index for a given latency; MEM_LAT is 1..4 so two bits suffice.
  function automatic logic [CNT_W-1:0] cnt_last(input int lat);
    return CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Winner selection between the fetch and data requesters.
// With ARB_ROUND_ROBIN_EN the previous winner yields on a tie; otherwise data always wins a tie.
module arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic    f_req,
  input  logic    d_req,
  input  req_id_t last,
  output req_id_t winner
);

`ifndef ARB_ROUND_ROBIN_EN
  // Fixed priority never consults the previous winner.
  logic last_unused_s;
  assign last_unused_s = last;
`endif

  // Tie-break between simultaneous requests; a lone request always wins.
  always_comb begin
    winner = REQ_DATA;
    if (f_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      if (last == REQ_DATA) begin
        winner = REQ_FETCH;
      end else begin
        winner = REQ_DATA;
      end
`else
      winner = REQ_DATA;
`endif
    end else if (f_req) begin
      winner = REQ_FETCH;
    end else begin
      winner = REQ_DATA;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-port RAM: IDLE -> ACCESS (MEM_LAT cycles) -> RESP.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking instead of data-over-fetch priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_done,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = cnt_last(MEM_LAT);

  logic [1:0]       state_r;
  logic [CNT_W-1:0] cnt_r;
  req_id_t          win_r;
  req_id_t          winner_s;
  req_id_t          last_s;
  logic             req_any_s;
  logic             f_gnt_r;
  logic             d_gnt_r;
  logic             f_done_r;
  logic             d_done_r;
  logic             mem_en_r;
  logic             mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;
  logic [DATA_W-1:0] f_rdata_r;
  logic [DATA_W-1:0] d_rdata_r;
  logic             busy_r;

  assign req_any_s = f_req || d_req;

  arb_pick u_arb_pick (
    .f_req  (f_req),
    .d_req  (d_req),
    .last   (last_s),
    .winner (winner_s)
  );

`ifdef ARB_ROUND_ROBIN_EN
  req_id_t last_r;

  // Remembers who won the most recent grant so the other side wins the next tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_r <= REQ_DATA;
    end else if (state_r == ST_IDLE && req_any_s) begin
      last_r <= winner_s;
    end else begin
      last_r <= last_r;
    end
  end

  assign last_s = last_r;
`else
  assign last_s = REQ_DATA;
`endif

  // Main FSM; mem_rdata is captured on the edge that leaves ACCESS so rdata is valid alongside done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      win_r       <= REQ_FETCH;
      f_gnt_r     <= 1'b0;
      d_gnt_r     <= 1'b0;
      f_done_r    <= 1'b0;
      d_done_r    <= 1'b0;
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      f_rdata_r   <= '0;
      d_rdata_r   <= '0;
      busy_r      <= 1'b0;
    end else begin
      f_gnt_r  <= 1'b0;
      d_gnt_r  <= 1'b0;
      f_done_r <= 1'b0;
      d_done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (req_any_s) begin
            state_r  <= ST_ACCESS;
            cnt_r    <= '0;
            win_r    <= winner_s;
            mem_en_r <= 1'b1;
            busy_r   <= 1'b1;
            if (winner_s == REQ_DATA) begin
              d_gnt_r     <= 1'b1;
              mem_we_r    <= d_we;
              mem_addr_r  <= d_addr;
              mem_wdata_r <= d_wdata;
            end else begin
              f_gnt_r     <= 1'b1;
              mem_we_r    <= 1'b0;
              mem_addr_r  <= f_addr;
              mem_wdata_r <= '0;
            end
          end
        end
        ST_ACCESS: begin
          if (cnt_r == CNT_LAST) begin
            state_r  <= ST_RESP;
            cnt_r    <= '0;
            mem_en_r <= 1'b0;
            mem_we_r <= 1'b0;
            if (win_r == REQ_DATA) begin
              d_done_r <= 1'b1;
              if (!mem_we_r) begin
                d_rdata_r <= mem_rdata;
              end
            end else begin
              f_done_r  <= 1'b1;
              f_rdata_r <= mem_rdata;
            end
          end else begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_RESP: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r  <= ST_IDLE;
          cnt_r    <= '0;
          mem_en_r <= 1'b0;
          mem_we_r <= 1'b0;
          busy_r   <= 1'b0;
        end
      endcase
    end
  end

  assign f_gnt     = f_gnt_r;
  assign d_gnt     = d_gnt_r;
  assign f_done    = f_done_r;
  assign d_done    = d_done_r;
  assign f_rdata   = f_rdata_r;
  assign d_rdata   = d_rdata_r;
  assign mem_en    = mem_en_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three instances (MEM_LAT 1, 3, 4) share stimulus and are checked each cycle
// against a transaction-level model; honours ARB_ROUND_ROBIN_EN for tie-break expectations.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int DW = 16;
  localparam int AW = 10;
  localparam int NI = 3;

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 3 : 4);
  endfunction

  logic          clk;
  logic          rst_n;
  logic          f_req, d_req, d_we;
  logic [AW-1:0] f_addr, d_addr;
  logic [DW-1:0] d_wdata, mem_rdata;

  logic          f_gnt [NI];
  logic          f_done [NI];
  logic          d_gnt [NI];
  logic          d_done [NI];
  logic          mem_en [NI];
  logic          mem_we [NI];
  logic          busy [NI];
  logic [DW-1:0] f_rdata [NI];
  logic [DW-1:0] d_rdata [NI];
  logic [AW-1:0] mem_addr [NI];
  logic [DW-1:0] mem_wdata [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MEM_LAT(lat_of(g))) u_dut (
      .clk(clk), .rst_n(rst_n),
      .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt[g]), .f_done(f_done[g]), .f_rdata(f_rdata[g]),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt[g]), .d_done(d_done[g]), .d_rdata(d_rdata[g]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]),
      .mem_rdata(mem_rdata), .busy(busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transaction model: k counts cycles since the grant edge (1..L = ACCESS, L+1 = RESP).
  bit            act [NI];
  int            k [NI];
  bit            who_d [NI];
  bit            m_we [NI];
  bit            last_d [NI];
  logic [AW-1:0] m_addr [NI];
  logic [DW-1:0] m_wdata [NI];
  logic [DW-1:0] m_frd [NI];
  logic [DW-1:0] m_drd [NI];

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s[inst%0d] observed=%0h expected=%0h", tag, i, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      act[i] = 1'b0; k[i] = 0; last_d[i] = 1'b1;
      m_frd[i] = '0; m_drd[i] = '0;
    end
  endtask

  // Applies one clock edge worth of the protocol rules, using the inputs as the DUT samples them.
  task automatic model_edge();
    bit pick_d;
    for (int i = 0; i < NI; i++) begin
      if (act[i]) begin
        k[i]++;
        if (k[i] == lat_of(i) + 1 && !m_we[i]) begin
          if (who_d[i]) m_drd[i] = mem_rdata;
          else          m_frd[i] = mem_rdata;
        end
        if (k[i] > lat_of(i) + 1) act[i] = 1'b0;
      end else if (f_req || d_req) begin
        if (f_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
          pick_d = !last_d[i];
`else
          pick_d = 1'b1;
`endif
        end else begin
          pick_d = d_req;
        end
        act[i] = 1'b1; k[i] = 1; who_d[i] = pick_d; last_d[i] = pick_d;
        m_we[i]    = pick_d ? d_we : 1'b0;
        m_addr[i]  = pick_d ? d_addr : f_addr;
        m_wdata[i] = d_wdata;
      end
    end
  endtask

  task automatic check_all();
    bit e_gnt, e_en, e_done;
    int l;
    for (int i = 0; i < NI; i++) begin
      l      = lat_of(i);
      e_gnt  = act[i] && k[i] == 1;
      e_en   = act[i] && k[i] >= 1 && k[i] <= l;
      e_done = act[i] && k[i] == l + 1;
      chk("f_gnt", i, f_gnt[i], e_gnt && !who_d[i]);
      chk("d_gnt", i, d_gnt[i], e_gnt && who_d[i]);
      chk("f_done", i, f_done[i], e_done && !who_d[i]);
      chk("d_done", i, d_done[i], e_done && who_d[i]);
      chk("mem_en", i, mem_en[i], e_en);
      chk("mem_we", i, mem_we[i], e_en && m_we[i]);
      chk("busy", i, busy[i], act[i]);
      chk("f_rdata", i, f_rdata[i], m_frd[i]);
      chk("d_rdata", i, d_rdata[i], m_drd[i]);
      if (e_en) chk("mem_addr", i, mem_addr[i], m_addr[i]);
      if (e_en && m_we[i]) chk("mem_wdata", i, mem_wdata[i], m_wdata[i]);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  // Mid-cycle asynchronous reset pulse, checked while still asserted.
  task automatic mid_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    for (int i = 0; i < NI; i++) begin
      chk("rst_mem_addr", i, mem_addr[i], 0);
      chk("rst_mem_wdata", i, mem_wdata[i], 0);
    end
    #1;
    rst_n = 1'b1;
  endtask

  task automatic idle_inputs();
    f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
  endtask

  task automatic drain();
    idle_inputs();
    repeat (7) step();
  endtask

  initial begin
    string order, exp_order;
    int    bcnt, dcyc;

    rst_n = 1'b0; idle_inputs();
    f_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    for (int i = 0; i < NI; i++) begin
      chk("rst_mem_addr", i, mem_addr[i], 0);
      chk("rst_mem_wdata", i, mem_wdata[i], 0);
    end
    #4 rst_n = 1'b1;
    repeat (2) step();

    // Single fetch read.
    f_req = 1'b1; f_addr = 10'h005; mem_rdata = 16'hBEEF;
    step();
    chk("r039_f_gnt", 0, f_gnt[0], 1);
    chk("r039_mem_en", 0, mem_en[0], 1);
    chk("r039_mem_addr", 0, mem_addr[0], 10'h005);
    f_req = 1'b0;
    step();
    chk("r039_f_done", 0, f_done[0], 1);
    step();
    chk("r039_f_rdata", 0, f_rdata[0], 16'hBEEF);
    drain();

    // Data write; d_rdata must not move.
    d_req = 1'b1; d_we = 1'b1; d_addr = 10'h3FF; d_wdata = 16'h1234; mem_rdata = 16'h5A5A;
    step();
    chk("r040_mem_we", 0, mem_we[0], 1);
    chk("r040_mem_addr", 0, mem_addr[0], 10'h3FF);
    chk("r040_mem_wdata", 0, mem_wdata[0], 16'h1234);
    idle_inputs();
    step();
    chk("r040_d_done", 0, d_done[0], 1);
    chk("r040_d_rdata", 0, d_rdata[0], 0);
    drain();

    // Fetch pulse during a data write's ACCESS is ignored.
    d_req = 1'b1; d_we = 1'b1; d_addr = 10'h011; d_wdata = 16'hCAFE;
    step();
    idle_inputs(); f_req = 1'b1;
    step();
    f_req = 1'b0;
    bcnt = 0;
    for (int c = 0; c < 7; c++) begin
      step();
      if (f_gnt[0] || mem_en[0]) bcnt++;
    end
    chk("r043_no_second", 0, bcnt, 0);

    // Both requesters held for 12 cycles.
    f_req = 1'b1; d_req = 1'b1; d_we = 1'b0; f_addr = 10'h0A0; d_addr = 10'h0B0; mem_rdata = 16'h7777;
    order = "";
    for (int c = 0; c < 12; c++) begin
      step();
      if (f_gnt[0]) order = {order, "F"};
      if (d_gnt[0]) order = {order, "D"};
    end
`ifdef ARB_ROUND_ROBIN_EN
    exp_order = "FDFD";
`else
    exp_order = "DDDD";
`endif
    vectors++;
    assert (order == exp_order) else begin
      miscompares++;
      $error("FAIL r041_order observed=%s expected=%s", order, exp_order);
    end
    drain();

    // Reset in the second ACCESS cycle of the MEM_LAT=3 instance.
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'h123;
    step();
    idle_inputs();
    step();
    chk("r042_pre_en", 1, mem_en[1], 1);
    mid_reset();
    chk("r042_en", 1, mem_en[1], 0);
    chk("r042_busy", 1, busy[1], 0);
    bcnt = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (d_done[1]) bcnt++;
    end
    chk("r042_no_done", 1, bcnt, 0);

    // Latency at MEM_LAT=4: done 5 cycles after the request edge, busy for 5 cycles.
    f_req = 1'b1; f_addr = 10'h2C4; mem_rdata = 16'h0F0F;
    bcnt = 0; dcyc = -1;
    for (int c = 1; c <= 8; c++) begin
      step();
      f_req = 1'b0;
      if (busy[2]) bcnt++;
      if (f_done[2]) dcyc = c;
    end
    chk("r044_done_cyc", 2, dcyc, 5);
    chk("r044_busy_cycles", 2, bcnt, 5);
    drain();

    // Randomized traffic with occasional asynchronous resets.
    for (int c = 0; c < 600; c++) begin
      f_req     = ($urandom_range(0, 2) == 0);
      d_req     = ($urandom_range(0, 2) == 0);
      d_we      = $urandom_range(0, 1) == 1;
      f_addr    = AW'($urandom);
      d_addr    = AW'($urandom);
      d_wdata   = DW'($urandom);
      mem_rdata = DW'($urandom);
      step();
      if ($urandom_range(0, 149) == 0) mid_reset();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
